pc_ctrl: RTL and testbench

- Fetch/branch sequencer that drives the program counter's control interface: inc, add, sub, offset and load.
- Reads the instruction at the current pc through a req/ack memory port and decodes control-flow opcodes. Issues exactly one pc update per instruction.
- Hands all non-control instructions to the execute stage.
- Sits between instruction memory and the pc block.

---
 rtl/pc_ctrl_if.sv | 24 ++
 rtl/pc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pc_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Instruction-memory read port between pc_ctrl (master) and instruction memory (slave).
// The address is held for as long as mem_req stays high; mem_ack qualifies mem_rdata.
interface pc_ctrl_if;
  localparam int unsigned W = 16;

  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/branch sequencer issuing one inc/add/sub + load update per instruction.
// Optional macro PC_CTRL_LINK_EN adds a link register with CALL (0x4) and RET (0x5).
module pc_ctrl #(
  parameter bit RESET_HALTED = 1'b0,
  localparam int unsigned W = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  pc,
  input  logic          zero,
  input  logic          resume,
  pc_ctrl_if.master     mem,
  output logic          inc,
  output logic          add,
  output logic          sub,
  output logic [W-1:0]  offset,
  output logic          load,
  output logic [W-1:0]  instr_out,
  output logic          instr_valid,
  output logic          halted
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned IMM_W = 12;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_JF   = 4'h1;
  localparam logic [OP_W-1:0] OP_JB   = 4'h2;
  localparam logic [OP_W-1:0] OP_BZ   = 4'h3;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
`ifdef PC_CTRL_LINK_EN
  localparam logic [OP_W-1:0] OP_CALL = 4'h4;
  localparam logic [OP_W-1:0] OP_RET  = 4'h5;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [W-1:0]    ir;
  logic [OP_W-1:0] op;
  logic [W-1:0]    imm;

  assign op        = ir[W-1:IMM_W];
  assign imm       = W'(ir[IMM_W-1:0]);
  assign instr_out = ir;

  // The read address simply follows the pc; it is only meaningful while mem_req is high.
  assign mem.mem_addr = pc;

  // State register and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_n;
      if (state == S_REQ && mem.mem_ack) begin
        ir <= mem.mem_rdata;
      end
    end
  end

`ifdef PC_CTRL_LINK_EN
  logic [W-1:0] link;

  // Return address captured while the CALL itself is executing.
  always_ff @(posedge clk) begin
    if (reset) begin
      link <= '0;
    end else if (state == S_EXEC && op == OP_CALL) begin
      link <= pc + W'(1);
    end
  end
`endif

  // Next-state and control decode; outputs depend only on state, ir and the pc/zero inputs.
  always_comb begin
    state_n      = state;
    mem.mem_req  = 1'b0;
    inc          = 1'b0;
    add          = 1'b0;
    sub          = 1'b0;
    offset       = '0;
    load         = 1'b0;
    instr_valid  = 1'b0;
    halted       = 1'b0;

    case (state)
      S_IDLE: begin
        state_n = RESET_HALTED ? S_HALT : S_REQ;
      end

      S_REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          state_n = S_EXEC;
        end
      end

      S_EXEC: begin
        load    = 1'b1;
        state_n = S_REQ;
        case (op)
          OP_NOP: begin
            inc = 1'b1;
          end
          OP_JF: begin
            add    = 1'b1;
            offset = imm;
          end
          OP_JB: begin
            sub    = 1'b1;
            offset = imm;
          end
          OP_BZ: begin
            if (zero) begin
              add    = 1'b1;
              offset = imm;
            end else begin
              inc = 1'b1;
            end
          end
`ifdef PC_CTRL_LINK_EN
          OP_CALL: begin
            add    = 1'b1;
            offset = imm;
          end
          // Subtracting the distance back to link lands the pc exactly on link.
          OP_RET: begin
            sub    = 1'b1;
            offset = pc - link;
          end
`endif
          OP_HALT: begin
            inc     = 1'b1;
            state_n = S_HALT;
          end
          default: begin
            inc         = 1'b1;
            instr_valid = 1'b1;
          end
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a pc model and instruction memory around the DUT,
// predictions queued at fetch acceptance and compared on each load strobe.
module tb_pc_ctrl;
  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          zero;
  logic          resume;
  logic [W-1:0]  pc;
  logic          inc, add, sub, load, instr_valid, halted;
  logic [W-1:0]  offset, instr_out;
  logic          h_inc, h_add, h_sub, h_load, h_instr_valid, h_halted;
  logic [W-1:0]  h_offset, h_instr_out;

  always #5 clk = ~clk;

  pc_ctrl_if bus ();
  pc_ctrl_if bus_h ();

  pc_ctrl #(.RESET_HALTED(1'b0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .zero(zero), .resume(resume), .mem(bus),
    .inc(inc), .add(add), .sub(sub), .offset(offset), .load(load),
    .instr_out(instr_out), .instr_valid(instr_valid), .halted(halted)
  );

  pc_ctrl #(.RESET_HALTED(1'b1)) dut_h (
    .clk(clk), .reset(reset), .pc(pc), .zero(zero), .resume(resume), .mem(bus_h),
    .inc(h_inc), .add(h_add), .sub(h_sub), .offset(h_offset), .load(h_load),
    .instr_out(h_instr_out), .instr_valid(h_instr_valid), .halted(h_halted)
  );

  assign bus_h.mem_ack   = 1'b0;
  assign bus_h.mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // pc block model
  logic          pc_wr;
  logic [W-1:0]  pc_wdata;
  always @(posedge clk) begin
    if (pc_wr)          pc <= pc_wdata;
    else if (load) begin
      if (inc)          pc <= pc + 16'd1;
      else if (add)     pc <= pc + offset;
      else if (sub)     pc <= pc - offset;
    end
  end

  // instruction memory with programmable ack latency
  logic [W-1:0]  imem [0:63];
  int unsigned   ack_dly;
  int unsigned   wait_cnt;
  logic          ack_force;
  always_comb bus.mem_rdata = imem[bus.mem_addr[5:0]];
  always_comb bus.mem_ack   = ack_force | (bus.mem_req && (wait_cnt >= ack_dly));
  always @(posedge clk) begin
    if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                                      wait_cnt <= wait_cnt + 1;
  end

  typedef struct packed {
    logic [W-1:0] word;
    logic         inc;
    logic         add;
    logic         sub;
    logic [W-1:0] offset;
    logic         iv;
    logic [W-1:0] nxt;
  } exp_t;

  function automatic exp_t predict(input logic [W-1:0] w, input logic [W-1:0] p,
                                   input logic z, input logic [W-1:0] lk);
    exp_t         e;
    logic [W-1:0] imm;
    imm    = {4'h0, w[11:0]};
    e      = '0;
    e.word = w;
    e.inc  = 1'b1;
    case (w[15:12])
      4'h0, 4'hF: ;
      4'h1: begin e.inc = 1'b0; e.add = 1'b1; e.offset = imm; end
      4'h2: begin e.inc = 1'b0; e.sub = 1'b1; e.offset = imm; end
      4'h3: if (z) begin e.inc = 1'b0; e.add = 1'b1; e.offset = imm; end
`ifdef PC_CTRL_LINK_EN
      4'h4: begin e.inc = 1'b0; e.add = 1'b1; e.offset = imm; end
      4'h5: begin e.inc = 1'b0; e.sub = 1'b1; e.offset = p - lk; end
`endif
      default: e.iv = 1'b1;
    endcase
    e.nxt = e.add ? p + e.offset : (e.sub ? p - e.offset : p + 16'd1);
    return e;
  endfunction

  exp_t          sbq [$];
  exp_t          push_e;
  exp_t          mon_e;
  logic [W-1:0]  exp_next;
  logic          nxt_valid = 1'b0;
  logic [W-1:0]  link_m;
  int            load_cnt = 0;

  // push a prediction whenever a fetch is accepted
  always @(posedge clk) begin
    if (reset) link_m <= '0;
    if (pc_wr) begin
      nxt_valid <= 1'b0;
    end else if (!reset && bus.mem_req && bus.mem_ack) begin
      if (nxt_valid) check("fetch_addr", 32'(bus.mem_addr), 32'(exp_next));
      push_e = predict(bus.mem_rdata, pc, zero, link_m);
      sbq.push_back(push_e);
      exp_next  <= push_e.nxt;
      nxt_valid <= 1'b1;
`ifdef PC_CTRL_LINK_EN
      if (bus.mem_rdata[15:12] == 4'h4) link_m <= pc + 16'd1;
`endif
    end
  end

  // pop and compare on every load; controls must be quiet otherwise
  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      check("load_with_req", 32'(bus.mem_req), 32'(1'b0));
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        mon_e = sbq.pop_front();
        check("exec_ctl", 32'({inc, add, sub, instr_valid}),
              32'({mon_e.inc, mon_e.add, mon_e.sub, mon_e.iv}));
        check("exec_offset", 32'(offset), 32'(mon_e.offset));
        check("exec_instr", 32'(instr_out), 32'(mon_e.word));
      end
    end else begin
      check("quiet_ctl", 32'({inc, add, sub, instr_valid, offset}), 32'd0);
    end
    if (bus.mem_req) check("addr_eq_pc", 32'(bus.mem_addr), 32'(pc));
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = '0;
  endtask

  task automatic start(input logic [W-1:0] p, input logic z, input int unsigned dly);
    @(negedge clk);
    reset = 1'b1; pc_wr = 1'b1; pc_wdata = p; zero = z; ack_dly = dly;
    resume = 1'b0; ack_force = 1'b0;
    @(negedge clk);
    pc_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_loads(input int n, input string tag, output int cycles);
    int tgt;
    tgt    = load_cnt + n;
    cycles = 0;
    while (load_cnt < tgt && cycles < 200) begin
      @(posedge clk);
      cycles++;
    end
    if (load_cnt < tgt) check({tag, "_timeout"}, 32'(load_cnt), 32'(tgt));
  endtask

  task automatic expect_fetch(input string tag, input logic [W-1:0] a, output int b);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus.mem_req && b < 50);
    if (!bus.mem_req) check({tag, "_timeout"}, 32'(bus.mem_req), 32'd1);
    else              check(tag, 32'(bus.mem_addr), 32'(a));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int cyc;
    int b;
    int n_req;
    int n_ld;
    logic got_ld;

    // reset with resume held: reset must win
    reset = 1'b1; resume = 1'b1; pc_wr = 1'b1; pc_wdata = '0; zero = 1'b0;
    ack_dly = 0; ack_force = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_ctl", 32'({inc, add, sub, instr_valid}), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr", 32'(instr_out), 32'd0);
    check("rst_h_halted", 32'(h_halted), 32'd0);

    // sequential fetch, JF, JB, ordinary instruction
    imem[6'h04] = 16'h1010;
    imem[6'h14] = 16'h2003;
    imem[6'h11] = 16'h7ABC;
    start(16'h0000, 1'b0, 0);
    expect_fetch("first_fetch", 16'h0000, b);
    check("first_req_latency", 32'(b), 32'd1);
    check("h_halted_after_idle", 32'(h_halted), 32'd1);
    check("h_no_req", 32'(bus_h.mem_req), 32'd0);
    wait_loads(1, "nop0", cyc);
    for (int i = 1; i < 4; i++) begin
      wait_loads(1, "nop", cyc);
      check("cadence", 32'(cyc), 32'd2);
    end
    wait_loads(1, "jf", cyc);
    expect_fetch("jf_target", 16'h0014, b);
    wait_loads(1, "jb", cyc);
    expect_fetch("jb_target", 16'h0011, b);
    @(negedge clk);
    check("iv_pulse", 32'(instr_valid), 32'd1);
    check("iv_instr", 32'(instr_out), 32'h7ABC);
    @(negedge clk);
    check("iv_single", 32'(instr_valid), 32'd0);

    // BZ taken with slow memory, then not taken
    clear_mem();
    imem[6'h08] = 16'h3005;
    start(16'h0008, 1'b1, 3);
    n_req = 0; got_ld = 1'b0; b = 0;
    while (!got_ld && b < 20) begin
      @(negedge clk);
      if (bus.mem_req) n_req++;
      if (load) got_ld = 1'b1;
      b++;
    end
    check("slow_ack_req_cycles", 32'(n_req), 32'd4);
    check("slow_ack_load", 32'(got_ld), 32'd1);
    expect_fetch("bz_taken", 16'h000D, b);
    start(16'h0008, 1'b0, 0);
    wait_loads(1, "bz_nt", cyc);
    expect_fetch("bz_not_taken", 16'h0009, b);

    // HALT: no requests, stray acks ignored, resume fetches past the HALT
    clear_mem();
    imem[6'h06] = 16'hF000;
    start(16'h0006, 1'b0, 0);
    wait_loads(1, "halt", cyc);
    @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    ack_force = 1'b1;
    n_req = 0; n_ld = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_req) n_req++;
      if (load) n_ld++;
    end
    check("halt_no_req", 32'(n_req), 32'd0);
    check("halt_no_load", 32'(n_ld), 32'd0);
    check("halt_stays", 32'(halted), 32'd1);
    ack_force = 1'b0;
    resume    = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_req", 32'(bus.mem_req), 32'd1);
    check("resume_addr", 32'(bus.mem_addr), 32'h0007);
    check("resume_unhalt", 32'(halted), 32'd0);
    check("h_resume_req", 32'(bus_h.mem_req), 32'd1);

    // reset while an ack is pending
    clear_mem();
    start(16'h0020, 1'b0, 1);
    @(negedge clk);
    check("midreq_wait", 32'({bus.mem_req, bus.mem_ack}), 32'b10);
    @(negedge clk);
    check("midreq_ack", 32'({bus.mem_req, bus.mem_ack}), 32'b11);
    reset = 1'b1;
    @(negedge clk);
    check("midreq_drop", 32'({bus.mem_req, load}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midreq_refetch", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 16'h0020}));
    wait_loads(1, "midreq_load", cyc);

    // CALL / RET
    clear_mem();
    imem[6'h10] = 16'h4020;
    imem[6'h30] = 16'h5000;
    start(16'h0010, 1'b0, 0);
    wait_loads(1, "call", cyc);
`ifdef PC_CTRL_LINK_EN
    expect_fetch("call_target", 16'h0030, b);
    check("link_value", 32'(dut.link), 32'h0011);
    wait_loads(1, "ret", cyc);
    expect_fetch("ret_target", 16'h0011, b);
`else
    expect_fetch("call_plain", 16'h0011, b);
    start(16'h0030, 1'b0, 0);
    wait_loads(1, "ret_plain", cyc);
    expect_fetch("ret_plain_next", 16'h0031, b);
`endif

    // JB wraps below zero; resume outside HALT has no effect
    clear_mem();
    imem[6'h02] = 16'h2005;
    start(16'h0002, 1'b0, 0);
    resume = 1'b1;
    wait_loads(1, "jb_wrap", cyc);
    expect_fetch("jb_wrap_addr", 16'hFFFD, b);
    resume = 1'b0;
    check("no_halt_on_resume", 32'(halted), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
